// File: rtl/sram_rw_port_ctrl_if.sv
// Request/response bundle between a requester (cache/queue logic) and
// sram_rw_port_ctrl: a write channel, a read channel and a read-response
// channel, each with a valid/ready handshake.
interface sram_rw_port_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
    input  wr_ready, rd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
    output wr_ready, rd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sram_rw_port_ctrl.sv
// sram_rw_port_ctrl: merges independent write and read request channels onto
// the single RW port of an RW0-style SRAM macro and returns read data through
// a small response FIFO with valid/ready backpressure.
// Read data is captured exactly one cycle after issue; a read is only issued
// when a FIFO slot is guaranteed, so the FIFO can never overflow.
// Optional macro SRAM_CTRL_INIT_EN: after reset, sweep the whole SRAM writing
// zero, one address per cycle, before accepting requests.
module sram_rw_port_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 64,
  parameter int RSP_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  sram_rw_port_ctrl_if.slave bus,
  output logic               init_done,
  output logic               sram_en,
  output logic               sram_wmode,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  input  logic [DATA_W-1:0]  sram_rdata
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

  // Which channel won the most recent tie; the other one wins the next tie.
  typedef enum logic { RR_WRITE = 1'b0, RR_READ = 1'b1 } rr_e;

  logic              init_write;
  logic [ADDR_W-1:0] init_addr;

`ifdef SRAM_CTRL_INIT_EN
  // Reset parks the sweep at its first address, so the first cycle after
  // reset release already writes address 0.
  typedef enum logic { S_INIT = 1'b0, S_DONE = 1'b1 } init_state_e;

  init_state_e       state_q, state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;

  // Init sweep state register; a reset mid-sweep restarts at address 0.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!reset_n) begin
      state_q     <= S_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // Init sweep next state: one zero write per cycle up to the last address.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == S_INIT) begin
      init_addr_d = init_addr_q + ADDR_W'(1);
      if (&init_addr_q) state_d = S_DONE;
    end
  end

  assign init_write = reset_n && (state_q == S_INIT);
  assign init_done  = reset_n && (state_q == S_DONE);
  assign init_addr  = init_addr_q;
`else
  assign init_write = 1'b0;
  assign init_done  = reset_n;
  assign init_addr  = '0;
`endif

  rr_e               rr_last_q;
  logic              inflight_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_prev;
  logic [DATA_W-1:0] rsp_mem [RSP_DEPTH];

  logic             active, push, pop, rd_ok, tie, wr_win, rd_win;
  logic [OCC_W-1:0] occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // init_done already folds in reset_n, so nothing is granted in reset.
  assign active = init_done;
  assign push   = inflight_q;
  assign pop    = bus.rsp_valid && bus.rsp_ready;

  // Slots already committed (queued + in flight) minus the one leaving now.
  assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign rd_ok     = occupancy < OCC_W'(RSP_DEPTH);

  // Arbitration: single grant per cycle, round-robin only on a real tie.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    tie    = 1'b0;
    wr_win = 1'b0;
    rd_win = 1'b0;
    if (active) begin
      tie = bus.wr_valid && bus.rd_valid && rd_ok;
      if (tie) begin
        if (rr_last_q == RR_READ) wr_win = 1'b1;
        else                      rd_win = 1'b1;
      end else if (bus.wr_valid) begin
        wr_win = 1'b1;
      end else if (bus.rd_valid && rd_ok) begin
        rd_win = 1'b1;
      end
    end
  end

  assign bus.wr_ready = active && !rd_win;
  assign bus.rd_ready = active && rd_ok && !wr_win;

  // SRAM port driven straight from the accepted request (or the init sweep).
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (init_write) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_addr;
    end else if (wr_win) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = bus.wr_addr;
      sram_wdata = bus.wr_data;
    end else if (rd_win) begin
      sram_en    = 1'b1;
      sram_addr  = bus.rd_addr;
    end
  end

  // Control state: tie tracking, in-flight read flag, FIFO pointers/count.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_last_q  <= RR_READ;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      if (tie) rr_last_q <= wr_win ? RR_WRITE : RR_READ;
      inflight_q <= rd_win;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Response storage: sram_rdata is sampled only in the cycle after a read.
  always_ff @(posedge clock) begin
    // NOTE: the data array is deliberately not reset; the count and pointers
    // decide what is valid, and resetting storage only costs logic.
    if (reset_n && push) rsp_mem[wr_ptr_q] <= sram_rdata;
  end

  // When empty the output keeps showing the entry most recently at the head.
  assign rd_ptr_prev   = (rd_ptr_q == '0) ? PTR_LAST : rd_ptr_q - PTR_W'(1);
  assign bus.rsp_valid = (count_q != '0);
  assign bus.rsp_data  = (count_q == '0) ? rsp_mem[rd_ptr_prev] : rsp_mem[rd_ptr_q];

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Testbench for sram_rw_port_ctrl: directed scenarios followed by random
// traffic, checked every cycle against a transaction-level reference model
// (a memory array plus a queue of outstanding read results with due cycles).
module tb_sram_rw_port_ctrl;
  localparam int AW    = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 2;
  localparam int NADDR = 1 << AW;
`ifdef SRAM_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic          init_done, sram_en, sram_wmode;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  sram_rw_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_rw_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .init_done  (init_done),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] init_word(input int i);
    return {32'(i) * 32'h9E37_79B9, 32'hC0DE_0000 ^ 32'(i)};
  endfunction

  // SRAM macro: read data valid only in the cycle after a read, noise otherwise.
  logic [DW-1:0] sram_mem [NADDR];
  logic          rd_pend;
  logic [DW-1:0] rd_q, garb;
  initial begin
    for (int i = 0; i < NADDR; i++) sram_mem[i] <= init_word(i);
    rd_pend <= 1'b0;
    forever begin
      @(posedge clock);
      if (sram_en && sram_wmode) sram_mem[sram_addr] <= sram_wdata;
      rd_pend <= sram_en && !sram_wmode;
      rd_q    <= sram_mem[sram_addr];
      garb    <= {$urandom, $urandom};
    end
  end
  assign sram_rdata = rd_pend ? rd_q : garb;

  // Reference model state.
  typedef struct { logic [DW-1:0] data; int due; } rsp_t;
  logic [DW-1:0] ref_mem [NADDR];
  rsp_t          pend [$];
  bit            tie_write_next, init_busy, last_ok;
  int            init_idx, cyc;
  logic [DW-1:0] last_pop;
  bit            exp_wr, exp_rd, exp_pop, exp_tie, act_wr_hs, act_rd_hs;
  int            n_cmp, n_mis;

  task automatic check_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_mis++;
      $error("FAIL %s: observed %h required %h", tag, obs, req);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic req);
    n_cmp++;
    assert (obs === req) else begin
      n_mis++;
      $error("FAIL %s: observed %b required %b", tag, obs, req);
    end
  endtask

  // Mid-cycle: predict this cycle's grants and outputs, compare with the DUT.
  task automatic evaluate();
    bit head_vis, rd_ok;
    exp_wr = 0; exp_rd = 0; exp_pop = 0; exp_tie = 0;
    act_wr_hs = bus.wr_valid && bus.wr_ready;
    act_rd_hs = bus.rd_valid && bus.rd_ready;
    if (!reset_n) begin
      check_bit("rst_wr_ready", bus.wr_ready, 1'b0);
      check_bit("rst_rd_ready", bus.rd_ready, 1'b0);
      check_bit("rst_sram_en", sram_en, 1'b0);
      check_bit("rst_sram_wmode", sram_wmode, 1'b0);
      check_word("rst_sram_addr", DW'(sram_addr), '0);
      check_word("rst_sram_wdata", sram_wdata, '0);
      check_bit("rst_init_done", init_done, 1'b0);
    end else if (init_busy) begin
      check_bit("init_done_low", init_done, 1'b0);
      check_bit("init_wr_ready", bus.wr_ready, 1'b0);
      check_bit("init_rd_ready", bus.rd_ready, 1'b0);
      check_bit("init_sram_en", sram_en, 1'b1);
      check_bit("init_sram_wmode", sram_wmode, 1'b1);
      check_word("init_sram_addr", DW'(sram_addr), DW'(init_idx));
      check_word("init_sram_wdata", sram_wdata, '0);
      check_bit("init_rsp_valid", bus.rsp_valid, 1'b0);
    end else begin
      head_vis = (pend.size() != 0) && (pend[0].due <= cyc);
      exp_pop  = head_vis && bus.rsp_ready;
      rd_ok    = (pend.size() - int'(exp_pop)) < DEPTH;
      exp_tie  = bus.wr_valid && bus.rd_valid && rd_ok;
      exp_wr   = bus.wr_valid && (!exp_tie || tie_write_next);
      exp_rd   = bus.rd_valid && rd_ok && (!exp_tie || !tie_write_next);
      check_bit("init_done", init_done, 1'b1);
      check_bit("wr_handshake", act_wr_hs, exp_wr);
      check_bit("rd_handshake", act_rd_hs, exp_rd);
      check_bit("sram_en", sram_en, exp_wr || exp_rd);
      if (exp_wr || exp_rd) begin
        check_bit("sram_wmode", sram_wmode, exp_wr);
        check_word("sram_addr", DW'(sram_addr), DW'(exp_wr ? bus.wr_addr : bus.rd_addr));
      end
      if (exp_wr) check_word("sram_wdata", sram_wdata, bus.wr_data);
      check_bit("rsp_valid", bus.rsp_valid, head_vis);
      if (head_vis)     check_word("rsp_data", bus.rsp_data, pend[0].data);
      else if (last_ok) check_word("rsp_data_hold", bus.rsp_data, last_pop);
    end
  endtask

  // Clock edge: commit the predicted transactions into the model.
  task automatic advance();
    if (!reset_n) begin
      pend.delete();
      tie_write_next = 1'b1;
      last_ok        = 1'b0;
      init_busy      = INIT_EN;
      init_idx       = 0;
    end else if (init_busy) begin
      ref_mem[init_idx] = '0;
      init_idx++;
      if (init_idx == NADDR) init_busy = 1'b0;
    end else begin
      if (exp_pop) begin
        last_pop = pend[0].data;
        last_ok  = 1'b1;
        void'(pend.pop_front());
      end
      if (exp_wr) ref_mem[bus.wr_addr] = bus.wr_data;
      if (exp_rd) pend.push_back('{data: ref_mem[bus.rd_addr], due: cyc + 2});
      if (exp_tie) tie_write_next = !tie_write_next;
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clock);
    evaluate();
    @(posedge clock);
    advance();
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset_n = 1'b0;
    repeat (n) cycle();
    reset_n = 1'b1;
  endtask

  task automatic write_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (act_wr_hs) break;
    end
    check_bit("wr_accept_in_time", act_wr_hs, 1'b1);
    bus.wr_valid = 1'b0;
  endtask

  task automatic read_req(input logic [AW-1:0] a);
    bus.rd_valid = 1'b1; bus.rd_addr = a;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (act_rd_hs) break;
    end
    check_bit("rd_accept_in_time", act_rd_hs, 1'b1);
    bus.rd_valid = 1'b0;
  endtask

  initial begin
    int issued;
    n_cmp = 0; n_mis = 0; cyc = 0;
    for (int i = 0; i < NADDR; i++) ref_mem[i] = init_word(i);
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0; bus.rsp_ready = 1'b0;

    apply_reset(2);
    if (INIT_EN) repeat (NADDR) cycle();

`ifdef SRAM_CTRL_INIT_EN
    // Init sweep finished exactly NADDR cycles after release; memory reads 0.
    check_bit("t6_init_done", init_done, 1'b1);
    read_req(AW'(3));
    cycle();
    check_bit("t6_rsp_valid", bus.rsp_valid, 1'b1);
    check_word("t6_read_zero", bus.rsp_data, '0);
    bus.rsp_ready = 1'b1;
    cycle();
`endif

    // Test 1: write then read back, response two cycles after read issue.
    bus.rsp_ready = 1'b0;
    write_req(AW'(5), 64'hDEAD_BEEF_0000_0001);
    read_req(AW'(5));
    check_bit("t1_not_early", bus.rsp_valid, 1'b0);
    cycle();
    check_bit("t1_rsp_valid", bus.rsp_valid, 1'b1);
    check_word("t1_rsp_data", bus.rsp_data, 64'hDEAD_BEEF_0000_0001);
    bus.rsp_ready = 1'b1;
    cycle();

    // Test 2: eight back-to-back reads with the consumer always ready.
    bus.rd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr = AW'(i);
      cycle();
      check_bit("t2_back_to_back", act_rd_hs, 1'b1);
    end
    bus.rd_valid = 1'b0;
    repeat (3) cycle();

    // Test 3: consumer stalled, only DEPTH reads may issue, rest after release.
    bus.rsp_ready = 1'b0;
    issued = 0;
    for (int k = 0; k < 6; k++) begin
      bus.rd_valid = 1'b1; bus.rd_addr = AW'(8 + issued);
      cycle();
      if (act_rd_hs) issued++;
    end
    check_word("t3_credit_limit", DW'(issued), DW'(DEPTH));
    check_bit("t3_rd_ready_low", bus.rd_ready, 1'b0);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 12 && issued < 4; k++) begin
      bus.rd_addr = AW'(8 + issued);
      cycle();
      if (act_rd_hs) issued++;
    end
    check_word("t3_rest_issued", DW'(issued), 64'd4);
    bus.rd_valid = 1'b0;
    repeat (4) cycle();

    // Test 4: both channels held; grants alternate starting with write.
    bus.wr_valid = 1'b1; bus.wr_addr = AW'($urandom); bus.wr_data = {$urandom, $urandom};
    bus.rd_valid = 1'b1; bus.rd_addr = AW'($urandom);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check_bit("t4_grant_wr", act_wr_hs, (k % 2) == 0);
      check_bit("t4_grant_rd", act_rd_hs, (k % 2) == 1);
      if (act_wr_hs) begin bus.wr_addr = AW'($urandom); bus.wr_data = {$urandom, $urandom}; end
      if (act_rd_hs) bus.rd_addr = AW'($urandom);
    end
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
    repeat (3) cycle();

    // Test 5: reset right after a read issue drops the read entirely.
    bus.rsp_ready = 1'b0;
    read_req(AW'(2));
    apply_reset(1);
`ifdef SRAM_CTRL_INIT_EN
    // Reset in the middle of the sweep restarts it at address 0.
    repeat (5) cycle();
    apply_reset(1);
    repeat (NADDR) cycle();
    check_bit("t6_restart_done", init_done, 1'b1);
`endif
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_bit("t5_no_rsp", bus.rsp_valid, 1'b0);
    end

    // Random traffic: requests held until accepted, random consumer stalls.
    for (int k = 0; k < 400; k++) begin
      if (!bus.wr_valid || act_wr_hs) begin
        bus.wr_valid = 1'($urandom_range(0, 1));
        bus.wr_addr  = AW'($urandom);
        bus.wr_data  = {$urandom, $urandom};
      end
      if (!bus.rd_valid || act_rd_hs) begin
        bus.rd_valid = 1'($urandom_range(0, 1));
        bus.rd_addr  = AW'($urandom);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0; bus.rsp_ready = 1'b1;
    repeat (5) cycle();
    check_word("drain_empty", DW'(pend.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
